// File: rtl/sdma_sport_rd_ctrl_pkg.sv
// Shared widths, source-port ids and FSM encoding for the SDMA source-port read sequencer.
package sdma_sport_rd_ctrl_pkg;

  localparam int unsigned SRCPORTID_W = 3;
  localparam int unsigned CACHE_DW    = 128;
  localparam int unsigned AHB_DW      = 32;
  localparam int unsigned CACHE_B     = CACHE_DW / 8;
  localparam int unsigned AHB_B       = AHB_DW / 8;
  localparam int unsigned STRB_W      = CACHE_B;
  localparam int unsigned OFF_W       = $clog2(CACHE_B);
  localparam int unsigned BEAT_W      = OFF_W + 1;

  localparam logic [SRCPORTID_W-1:0] SPORT_AHB = 3'b000;
  localparam logic [SRCPORTID_W-1:0] SPORT_DC1 = 3'b100;
  localparam logic [SRCPORTID_W-1:0] SPORT_DC2 = 3'b101;
  localparam logic [SRCPORTID_W-1:0] SPORT_WC1 = 3'b110;
  localparam logic [SRCPORTID_W-1:0] SPORT_WC2 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Anything not a cache port falls back to AHB width, like the rdata mux default.
  function automatic logic is_cache_port(input logic [SRCPORTID_W-1:0] id);
    return id inside {SPORT_DC1, SPORT_DC2, SPORT_WC1, SPORT_WC2};
  endfunction

endpackage

// File: rtl/sdma_sport_beat_calc.sv
// Per-beat geometry: beat offset, byte count and expected byte mask for the current address.
module sdma_sport_beat_calc
  import sdma_sport_rd_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic [SRCPORTID_W-1:0] id,
  input  logic [OFF_W-1:0]       addr_lo,
  input  logic [LEN_W-1:0]       rem,
  output logic [OFF_W-1:0]       off,
  output logic [BEAT_W-1:0]      n,
  output logic [STRB_W-1:0]      mask
);

  logic [BEAT_W-1:0] bsize;
  logic [BEAT_W-1:0] room;

  always_comb begin
    bsize = is_cache_port(id) ? BEAT_W'(CACHE_B) : BEAT_W'(AHB_B);
    off   = addr_lo & OFF_W'(bsize - BEAT_W'(1));
    room  = bsize - BEAT_W'(off);
    n     = (rem < LEN_W'(room)) ? BEAT_W'(rem) : room;
    mask  = '0;
    for (int i = 0; i < STRB_W; i++) begin
      mask[i] = (BEAT_W'(i) >= BEAT_W'(off)) && (BEAT_W'(i) < BEAT_W'(off) + n);
    end
  end

endmodule

// File: rtl/sdma_sport_rd_ctrl.sv
// Source-port read sequencer: one beat outstanding, single-entry output buffer.
// Optional response watchdog enabled by defining SDMA_SPORT_TMO_EN.
module sdma_sport_rd_ctrl
  import sdma_sport_rd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_inst_vld,
  output logic                   o_inst_rdy,
  input  logic [SRCPORTID_W-1:0] i_inst_srcportid,
  input  logic [ADDR_W-1:0]      i_inst_saddr,
  input  logic [LEN_W-1:0]       i_inst_len,
  output logic [SRCPORTID_W-1:0] o_inst_srcportid,
  output logic                   o_sport_rreq,
  output logic [ADDR_W-1:0]      o_sport_raddr,
  input  logic                   i_sport_rgnt,
  input  logic [CACHE_DW-1:0]    i_sport_rdata,
  input  logic [STRB_W-1:0]      i_sport_rvld,
  output logic [CACHE_DW-1:0]    o_rd_data,
  output logic [STRB_W-1:0]      o_rd_strb,
  output logic                   o_rd_vld,
  input  logic                   i_rd_rdy,
  output logic                   o_rd_last,
  output logic                   o_done,
  output logic                   o_err
);

  state_e            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [OFF_W-1:0]  off;
  logic [BEAT_W-1:0] n;
  logic [STRB_W-1:0] mask;
  logic              last_beat;

  sdma_sport_beat_calc #(.LEN_W(LEN_W)) u_beat_calc (
    .id      (o_inst_srcportid),
    .addr_lo (addr_q[OFF_W-1:0]),
    .rem     (rem_q),
    .off     (off),
    .n       (n),
    .mask    (mask)
  );

  assign last_beat = (rem_q == LEN_W'(n));

`ifdef SDMA_SPORT_TMO_EN
  localparam int unsigned CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  logic [CNT_W-1:0] tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo = ^32'(TMO_CYC);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      addr_q           <= '0;
      rem_q            <= '0;
      o_inst_rdy       <= 1'b0;
      o_inst_srcportid <= SPORT_AHB;
      o_sport_rreq     <= 1'b0;
      o_sport_raddr    <= '0;
      o_rd_data        <= '0;
      o_rd_strb        <= '0;
      o_rd_vld         <= 1'b0;
      o_rd_last        <= 1'b0;
      o_done           <= 1'b0;
      o_err            <= 1'b0;
`ifdef SDMA_SPORT_TMO_EN
      tmo_cnt          <= '0;
`endif
    end else begin
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_inst_rdy <= 1'b0;
      if (o_rd_vld && i_rd_rdy) o_rd_vld <= 1'b0;

      case (state)
        ST_IDLE: begin
          o_inst_rdy <= 1'b1;
          if (i_inst_vld && o_inst_rdy) begin
            o_inst_rdy       <= 1'b0;
            o_inst_srcportid <= i_inst_srcportid;
            addr_q           <= i_inst_saddr;
            rem_q            <= i_inst_len;
            if (i_inst_len == '0) begin
              o_done <= 1'b1;
              o_err  <= 1'b1;
            end else begin
              state <= ST_REQ;
            end
          end
        end

        // Request only once the buffer is (or is becoming) free, so a beat never overwrites one.
        ST_REQ: begin
          if (o_sport_rreq && i_sport_rgnt) begin
            o_sport_rreq <= 1'b0;
            state        <= ST_WAIT;
`ifdef SDMA_SPORT_TMO_EN
            tmo_cnt      <= '0;
`endif
          end else begin
            o_sport_rreq  <= !o_rd_vld || i_rd_rdy;
            o_sport_raddr <= addr_q - ADDR_W'(off);
          end
        end

        ST_WAIT: begin
          if (|i_sport_rvld) begin
            o_rd_data <= i_sport_rdata;
            o_rd_strb <= i_sport_rvld & mask;
            o_rd_last <= last_beat;
            o_rd_vld  <= 1'b1;
            addr_q    <= addr_q + ADDR_W'(n);
            rem_q     <= rem_q - LEN_W'(n);
            state     <= last_beat ? ST_DONE : ST_REQ;
          end
`ifdef SDMA_SPORT_TMO_EN
          else if (tmo_cnt == CNT_W'(TMO_CYC - 1)) begin
            o_done   <= 1'b1;
            o_err    <= 1'b1;
            o_rd_vld <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
`endif
        end

        ST_DONE: begin
          if (o_rd_vld && i_rd_rdy) begin
            o_done <= 1'b1;
            state  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
